// File: rtl/fhe_cmd_issuer.sv
// fhe_cmd_issuer: queues host commands and strobes them onto the FHE ALU command port.
// Config commands stream back-to-back; operation commands hold the queue until done or watchdog.
module fhe_cmd_issuer #(
    parameter int COMMAND_WIDTH  = 8,
    parameter int FSIZE          = 64,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_push_valid,
    input  logic [COMMAND_WIDTH-1:0]   i_push_command,
    input  logic [FSIZE-1:0]           i_push_data0,
    input  logic [FSIZE-1:0]           i_push_data1,
    output logic                       o_push_ready,
    output logic                       o_cmd_valid,
    output logic [COMMAND_WIDTH-1:0]   o_cmd_command,
    output logic [FSIZE-1:0]           o_cmd_data0,
    output logic [FSIZE-1:0]           o_cmd_data1,
    input  logic                       i_alu_done,
    input  logic                       i_clear_err,
    output logic                       o_busy,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [31:0]                o_issued_cnt,
    output logic                       o_err_overflow,
    output logic                       o_err_unknown,
    output logic                       o_err_timeout,
    output logic                       o_err_spurious
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int EW = COMMAND_WIDTH + 2 * FSIZE;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                   state, state_next;
    logic [EW-1:0]            mem [DEPTH];
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            count, count_next;
    logic [TW-1:0]            timer, timer_next;
    logic                     push_acc, pop, issue, blocking, unknown, timeout_hit;
    logic [COMMAND_WIDTH-1:0] head_cmd;
    logic [FSIZE-1:0]         head_d0, head_d1;

    function automatic logic is_config(input logic [COMMAND_WIDTH-1:0] c);
        int unsigned v;
        v = 32'(c);
        return (v >= 1 && v <= 3) || v == 12 || v == 13 || (v >= 20 && v <= 29) || v == 111;
    endfunction

    function automatic logic is_blocking(input logic [COMMAND_WIDTH-1:0] c);
        int unsigned v;
        v = 32'(c);
        return (v >= 4 && v <= 6) || v == 10 || v == 11 || (v >= 41 && v <= 44)
            || (v >= 51 && v <= 72) || (v >= 80 && v <= 92);
    endfunction

    assign o_push_ready = (count != CW'(DEPTH));
    assign o_busy       = (state != IDLE) || (count != '0);
    assign o_count      = count;

    always_comb begin
        {head_cmd, head_d0, head_d1} = mem[rd_ptr];
        push_acc    = i_push_valid && (count != CW'(DEPTH));
        pop         = (state != WAIT) && (count != '0);
        blocking    = is_blocking(head_cmd);
        unknown     = !blocking && !is_config(head_cmd);
        issue       = pop && !unknown;
        count_next  = count + CW'(push_acc) - CW'(pop);
        timer_next  = timer;
        timeout_hit = 1'b0;
        state_next  = state;
        case (state)
            IDLE, ISSUE: begin
                if (issue && blocking) begin
                    state_next = WAIT;
                    timer_next = '0;
                end else begin
                    state_next = (count_next != '0) ? ISSUE : IDLE;
                end
            end
            WAIT: begin
                // A done pulse on the same edge as the watchdog expiry counts as a clean completion.
                if (i_alu_done) begin
                    state_next = (count_next != '0) ? ISSUE : IDLE;
                end else begin
                    timer_next = timer + TW'(1);
                    if (timer_next == TW'(TIMEOUT_CYCLES)) begin
                        timeout_hit = 1'b1;
                        state_next  = (count_next != '0) ? ISSUE : IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr] <= {i_push_command, i_push_data0, i_push_data1};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            timer          <= '0;
            o_cmd_valid    <= 1'b0;
            o_cmd_command  <= '0;
            o_cmd_data0    <= '0;
            o_cmd_data1    <= '0;
            o_issued_cnt   <= '0;
            o_err_overflow <= 1'b0;
            o_err_unknown  <= 1'b0;
            o_err_timeout  <= 1'b0;
            o_err_spurious <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            timer       <= timer_next;
            o_cmd_valid <= issue;
            if (push_acc) wr_ptr <= wr_ptr + PW'(1);
            if (pop)      rd_ptr <= rd_ptr + PW'(1);
            if (issue) begin
                o_cmd_command <= head_cmd;
                o_cmd_data0   <= head_d0;
                o_cmd_data1   <= head_d1;
                o_issued_cnt  <= o_issued_cnt + 32'd1;
            end
            // Sticky flags: a new event on the clearing edge keeps its flag set.
            o_err_overflow <= (i_push_valid && !push_acc) || (o_err_overflow && !i_clear_err);
            o_err_unknown  <= (pop && unknown) || (o_err_unknown && !i_clear_err);
            o_err_timeout  <= timeout_hit || (o_err_timeout && !i_clear_err);
            o_err_spurious <= (i_alu_done && state != WAIT) || (o_err_spurious && !i_clear_err);
        end
    end
endmodule
